// File: rtl/prefetch_buffer.sv
// Instruction prefetch unit: pipelined bus fetch into a small word FIFO, RVC
// realignment, and one instruction plus PC per handshake toward decode.
module prefetch_buffer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          DEPTH    = 3,
  parameter int          NUM_REQS = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        out_compressed_o,
  output logic        out_err_o,
  output logic        busy_o
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_n [DEPTH];
  logic [DEPTH-1:0] err_q, err_n;
  logic [CW-1:0]    count_q, count_n, outstanding_q, outstanding_n, discard_q, wr_idx;
  logic [31:0]      fetch_addr_q, pc_q;
  logic             started_q;
  logic [CW:0]      reserved;
  logic             gnt_acc, drop, push, pop, fire;
  logic             has0, has1, compressed;
  logic [15:0]      half;

  // Space for every granted word is reserved up front, so a response can
  // always be written without back-pressure on the bus.
  assign reserved     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign instr_req_o  = started_q && !branch_i &&
                        (outstanding_q < CW'(NUM_REQS)) && (reserved < (CW+1)'(DEPTH));
  assign instr_addr_o = fetch_addr_q;
  assign gnt_acc      = instr_gnt_i && (instr_req_o || branch_i);
  assign outstanding_n = outstanding_q + {{(CW-1){1'b0}}, gnt_acc}
                                       - {{(CW-1){1'b0}}, instr_rvalid_i};
  assign drop         = instr_rvalid_i && (discard_q != '0);
  assign push         = instr_rvalid_i && !drop;
  assign busy_o       = (outstanding_q != '0);

  assign has0       = (count_q != '0);
  assign has1       = (count_q > CW'(1));
  assign half       = pc_q[1] ? data_q[0][31:16] : data_q[0][15:0];
  assign compressed = (half[1:0] != 2'b11);

  always_comb begin
    out_instr_o      = data_q[0];
    out_valid_o      = has0;
    out_err_o        = err_q[0];
    out_compressed_o = compressed;
    if (compressed) begin
      out_instr_o = {16'h0000, half};
    end else if (pc_q[1]) begin
      // Upper half of entry0 followed by lower half of entry1; an erroring
      // first half is reported without waiting for the second word.
      out_instr_o = {data_q[1][15:0], data_q[0][31:16]};
      out_valid_o = has0 && (has1 || err_q[0]);
      out_err_o   = err_q[0] || (has1 && err_q[1]);
    end
  end
  assign out_pc_o = pc_q;

  // Handshake: an instruction transfers on any cycle where out_valid_o and
  // out_ready_i are both high; a transfer offered during a branch is void.
  assign fire   = out_valid_o && out_ready_i && !branch_i;
  assign pop    = fire && (pc_q[1] || !compressed);
  assign wr_idx = count_q - {{(CW-1){1'b0}}, pop};

  always_comb begin
    data_n  = data_q;
    err_n   = err_q;
    count_n = count_q - {{(CW-1){1'b0}}, pop} + {{(CW-1){1'b0}}, push};
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        data_n[i] = data_q[i+1];
        err_n[i]  = err_q[i+1];
      end
      data_n[DEPTH-1] = '0;
      err_n[DEPTH-1]  = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == CW'(i))) begin
        data_n[i] = instr_rdata_i;
        err_n[i]  = instr_err_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q        <= '{default: '0};
      err_q         <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      started_q     <= 1'b0;
      fetch_addr_q  <= {PC_RESET[31:2], 2'b00};
      pc_q          <= {PC_RESET[31:1], 1'b0};
    end else begin
      started_q     <= 1'b1;
      outstanding_q <= outstanding_n;
      data_q        <= data_n;
      err_q         <= err_n;
      if (branch_i) begin
        // Everything still in flight after this cycle belongs to the old path.
        count_q      <= '0;
        discard_q    <= outstanding_n;
        fetch_addr_q <= {branch_addr_i[31:2], 2'b00};
        pc_q         <= {branch_addr_i[31:1], 1'b0};
      end else begin
        count_q   <= count_n;
        discard_q <= discard_q - {{(CW-1){1'b0}}, drop};
        if (gnt_acc) fetch_addr_q <= fetch_addr_q + 32'd4;
        if (fire)    pc_q <= pc_q + (compressed ? 32'd2 : 32'd4);
      end
    end
  end
endmodule
